sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- N-port arbiter between the per-port Wishbone buffer blocks (sdram_clk side) and the single SDRAM controller access interface.
- Generalises the previous 2-port arbiter:
  - true parametrised round-robin, or fixed priority, selectable by MODE;
  - explicit ARB/BUSY/DRAIN state machine;
  - optional quantum-based preemption, so one port's long burst cannot starve the others.
- Read data from the controller fans out to all ports externally and does not pass through this block.

Parameters:
- NUM_PORTS, 3: number of requesting ports, 2..16.
- MODE, 0: 0 = round-robin; 1 = fixed priority, lowest index highest.
- QUANTUM, 16: acks granted before preemption is allowed when another port requests; 0 disables preemption.
- ENC_W, 2: width of grant_enc_o; must be >= clog2(NUM_PORTS).

Ports:
- sdram_clk  in  1  sole clock.
- sdram_rst  in  1  asynchronous, active-high reset.
- sdram_idle_i  in  1  controller idle, i.e. no access in flight.
- p_acc_i  in  NUM_PORTS  per-port access request; held until the port's transfer completes.
- p_we_i  in  NUM_PORTS  per-port write enable.
- p_adr_i  in  NUM_PORTS*32  per-port address; port k occupies bits [32k+31:32k].
- p_dat_i  in  NUM_PORTS*16  per-port write data.
- p_sel_i  in  NUM_PORTS*2  per-port byte selects.
- p_ack_o  out  NUM_PORTS  ack_i routed to the granted port only.
- adr_o  out  32  muxed address.
- dat_o  out  16  muxed write data.
- sel_o  out  2  muxed byte selects.
- we_o  out  1  muxed write enable.
- acc_o  out  1  access request to the controller.
- ack_i  in  1  controller word ack.
- grant_o  out  NUM_PORTS  one-hot owner; all zeros when no port owns the bus.
- grant_enc_o  out  ENC_W  binary index of the owner.
- preempt_o  out  1  high while in DRAIN.

Behaviour:
- Reset (async assert, release synchronous to sdram_clk):
  - state = ARB; grant_o = 0; grant_enc_o = 0; acc_o = 0; p_ack_o = 0; preempt_o = 0;
  - rr pointer = NUM_PORTS-1, so port 0 is searched first; ack counter = 0.
- Datapath: adr_o/dat_o/sel_o/we_o are combinational muxes on grant_enc_o, and are valid whenever grant_o != 0.
- acc_o = (state == BUSY) & p_acc_i[grant_enc_o].
- p_ack_o[k] = ack_i & grant_o[k]. An ack arriving when grant_o == 0 is dropped.
- State ARB:
  - If p_acc_i == 0, stay in ARB.
  - Otherwise select the winner W:
    - round-robin: first set bit scanning from pointer+1 upward, modulo NUM_PORTS;
    - priority: lowest set index.
  - Next edge: grant_o = onehot(W), grant_enc_o = W, counter = 0, state = BUSY.
  - Request-to-acc_o latency is 1 cycle.
- State BUSY:
  - Each ack_i increments the counter, saturating at QUANTUM.
  - Release condition: p_acc_i[owner] == 0 and sdram_idle_i. Then go to ARB, set pointer = owner, clear grant_o.
  - Preempt condition: QUANTUM != 0, counter == QUANTUM, and any other p_acc_i bit set. Then go to DRAIN.
    - In MODE 1, "other" means only a lower index than the owner.
  - If release and preempt are true in the same cycle, release wins.
- State DRAIN:
  - acc_o forced 0; grant_o is held so in-flight acks still reach the owner; preempt_o = 1.
  - When sdram_idle_i: go to ARB, set pointer = owner, clear grant_o.
  - The preempted port keeps p_acc_i high and competes again normally; its burst resumes at its current word.
- Invariants:
  - At most one grant_o bit is set.
  - grant_o never changes except on entry to BUSY or exit to ARB.
  - The minimum gap between two different owners is 1 ARB cycle.
- Simultaneous requests in ARB resolve in a single cycle.
- A request that drops while in ARB is never granted.
- Reset asserted mid-burst: all outputs go to their reset values immediately (async); no ack reaches any port afterward.

Decomposition:
- Shared include sdram_arb_defs.vh:
  - state encodings ARB = 2'd0, BUSY = 2'd1, DRAIN = 2'd2;
  - constants MODE_RR = 0, MODE_PRIO = 1.
- Sub-module arb_pick (combinational): inputs req, pointer, mode; outputs one-hot winner and encoded index.
- The top level holds the FSM, counter, pointer and muxes.

Test Plan:
- Round-robin fairness: NUM_PORTS = 3, MODE = 0, all p_acc_i held high, each port completes after 2 acks → grant sequence 0, 1, 2, 0, 1; acc_o high exactly 1 cycle after each ARB.
- Priority: MODE = 1, ports 2 and 0 request together in ARB → port 0 granted. Port 1 requests during port 0's burst → no preemption of port 0. After release → port 1 granted, then port 2.
- Preemption: QUANTUM = 4, port 0 requests a 10-word burst, port 1 requests at ack 2:
  - after the 4th ack → DRAIN, preempt_o = 1, acc_o = 0;
  - on sdram_idle_i → port 1 granted;
  - after port 1 releases → port 0 resumes and receives its remaining 6 acks.
- Ack routing: during port 2's grant, drive ack_i for 3 cycles → only p_ack_o[2] pulses 3 times. ack_i driven in ARB → p_ack_o stays 0.
- Release/preempt collision: counter reaches QUANTUM in the same cycle the owner drops p_acc_i with sdram_idle_i = 1 → ARB, not DRAIN; preempt_o never asserted.
- Async reset mid-BUSY: assert sdram_rst between clock edges → grant_o = 0 and acc_o = 0 before the next edge. After release, with ports 1 and 2 requesting, port 1 is granted (pointer reset).

Source files
------------

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter.
// FSM state encodings and arbitration mode constants.
package sdram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int MODE_RR   = 0;
  localparam int MODE_PRIO = 1;

endpackage

// File: rtl/sdram_port_arbiter_pick.sv
// Combinational winner selection for the SDRAM port arbiter.
// Round-robin scans upward from pointer+1; priority picks lowest index.
module arb_pick #(
  parameter int NUM_PORTS = 3,
  parameter int ENC_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ENC_W-1:0]     pointer,
  input  logic                 mode,
  output logic [NUM_PORTS-1:0] win,
  output logic [ENC_W-1:0]     win_enc
);

  logic                 found;
  int                   idx;
  logic [NUM_PORTS-1:0] sh;

  // first requesting port in scan order wins
  always_comb begin
    win     = '0;
    win_enc = '0;
    found   = 1'b0;
    idx     = 0;
    sh      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mode)
        idx = i;
      else
        idx = (int'(pointer) + 1 + i) % NUM_PORTS;
      sh = req >> idx;
      if (!found && sh[0]) begin
        found   = 1'b1;
        win     = NUM_PORTS'(1) << idx;
        win_enc = ENC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// N-port arbiter in front of the SDRAM controller access interface.
// Round-robin or fixed priority, with quantum-based preemption via DRAIN.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int MODE      = 0,
  parameter int QUANTUM   = 16,
  parameter int ENC_W     = 2
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_rst,
  input  logic                   sdram_idle_i,
  input  logic [NUM_PORTS-1:0]   p_acc_i,
  input  logic [NUM_PORTS-1:0]   p_we_i,
  input  logic [NUM_PORTS*32-1:0] p_adr_i,
  input  logic [NUM_PORTS*16-1:0] p_dat_i,
  input  logic [NUM_PORTS*2-1:0] p_sel_i,
  output logic [NUM_PORTS-1:0]   p_ack_o,
  output logic [31:0]            adr_o,
  output logic [15:0]            dat_o,
  output logic [1:0]             sel_o,
  output logic                   we_o,
  output logic                   acc_o,
  input  logic                   ack_i,
  output logic [NUM_PORTS-1:0]   grant_o,
  output logic [ENC_W-1:0]       grant_enc_o,
  output logic                   preempt_o
);

  localparam int CNT_W = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
  localparam logic [CNT_W-1:0] Q_MAX = CNT_W'(QUANTUM);
  localparam logic IS_PRIO = (MODE == MODE_PRIO);
  localparam logic Q_ON = (QUANTUM != 0);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [ENC_W-1:0]     enc_q, enc_d;
  logic [ENC_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] pick_win;
  logic [ENC_W-1:0]     pick_enc;
  logic                 own_req;
  logic                 others;
  logic                 release_c;
  logic                 preempt_c;

  logic [31:0] adr_a [NUM_PORTS];
  logic [15:0] dat_a [NUM_PORTS];
  logic [1:0]  sel_a [NUM_PORTS];

  arb_pick #(
    .NUM_PORTS(NUM_PORTS),
    .ENC_W    (ENC_W)
  ) u_pick (
    .req    (p_acc_i),
    .pointer(ptr_q),
    .mode   (IS_PRIO),
    .win    (pick_win),
    .win_enc(pick_enc)
  );

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slice
    assign adr_a[k] = p_adr_i[32*k +: 32];
    assign dat_a[k] = p_dat_i[16*k +: 16];
    assign sel_a[k] = p_sel_i[2*k +: 2];
  end

  assign adr_o = adr_a[enc_q];
  assign dat_o = dat_a[enc_q];
  assign sel_o = sel_a[enc_q];
  assign we_o  = p_we_i[enc_q];

  assign own_req   = |(p_acc_i & grant_q);
  assign others    = IS_PRIO ? |(p_acc_i & (grant_q - NUM_PORTS'(1)))
                             : |(p_acc_i & ~grant_q);
  assign release_c = ~own_req & sdram_idle_i;
  assign preempt_c = Q_ON & (cnt_q == Q_MAX) & others;

  assign acc_o       = (state_q == BUSY) & own_req;
  assign p_ack_o     = {NUM_PORTS{ack_i}} & grant_q;
  assign grant_o     = grant_q;
  assign grant_enc_o = enc_q;
  assign preempt_o   = (state_q == DRAIN);

  // next-state: grant, pointer and quantum counter
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    enc_d   = enc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB: begin
        if (|p_acc_i) begin
          grant_d = pick_win;
          enc_d   = pick_enc;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ack_i && cnt_q != Q_MAX)
          cnt_d = cnt_q + CNT_W'(1);
        if (release_c) begin
          state_d = ARB;
          ptr_d   = enc_q;
          grant_d = '0;
        end else if (preempt_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (sdram_idle_i) begin
          state_d = ARB;
          ptr_d   = enc_q;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ARB;
        grant_d = '0;
      end
    endcase
  end

  // state register, asynchronous reset
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state_q <= ARB;
      grant_q <= '0;
      enc_q   <= '0;
      ptr_q   <= ENC_W'(NUM_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      enc_q   <= enc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: RR and priority instances side by side.
// Per-cycle expectations are queued and compared by a negedge monitor.
module tb_sdram_port_arbiter;

  localparam int NP = 3;
  localparam int Q  = 4;

  typedef struct packed {
    logic          d;
    logic [NP-1:0] grant;
    logic [1:0]    enc;
    logic          acc;
    logic          pre;
    logic [NP-1:0] pk;
    logic [31:0]   adr;
    logic [15:0]   dat;
    logic [1:0]    sel;
    logic          we;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             idle [2];
  logic             ack  [2];
  logic [NP-1:0]    pacc [2];
  logic [NP-1:0]    pwe  [2];
  logic [NP*32-1:0] padr [2];
  logic [NP*16-1:0] pdat [2];
  logic [NP*2-1:0]  psel [2];
  logic [NP-1:0]    pack [2];
  logic [NP-1:0]    grant [2];
  logic [31:0]      adr_o [2];
  logic [15:0]      dat_o [2];
  logic [1:0]       sel_o [2];
  logic [1:0]       genc [2];
  logic             we_o [2];
  logic             acc_o [2];
  logic             pre [2];

  sdram_port_arbiter #(.NUM_PORTS(NP), .MODE(0), .QUANTUM(Q), .ENC_W(2)) u_rr (
    .sdram_clk(clk), .sdram_rst(rst), .sdram_idle_i(idle[0]),
    .p_acc_i(pacc[0]), .p_we_i(pwe[0]), .p_adr_i(padr[0]),
    .p_dat_i(pdat[0]), .p_sel_i(psel[0]), .p_ack_o(pack[0]),
    .adr_o(adr_o[0]), .dat_o(dat_o[0]), .sel_o(sel_o[0]), .we_o(we_o[0]),
    .acc_o(acc_o[0]), .ack_i(ack[0]), .grant_o(grant[0]),
    .grant_enc_o(genc[0]), .preempt_o(pre[0])
  );

  sdram_port_arbiter #(.NUM_PORTS(NP), .MODE(1), .QUANTUM(Q), .ENC_W(2)) u_pr (
    .sdram_clk(clk), .sdram_rst(rst), .sdram_idle_i(idle[1]),
    .p_acc_i(pacc[1]), .p_we_i(pwe[1]), .p_adr_i(padr[1]),
    .p_dat_i(pdat[1]), .p_sel_i(psel[1]), .p_ack_o(pack[1]),
    .adr_o(adr_o[1]), .dat_o(dat_o[1]), .sel_o(sel_o[1]), .we_o(we_o[1]),
    .acc_o(acc_o[1]), .ack_i(ack[1]), .grant_o(grant[1]),
    .grant_enc_o(genc[1]), .preempt_o(pre[1])
  );

  int nchk = 0;
  int nerr = 0;

  // reference model: owner (-1 none), draining flag, acks this tenure, last owner
  int own [2];
  int last [2];
  int acks [2];
  bit drn [2];
  int rem [2][NP];
  bit was_zero [2][NP];
  bit refill [2];

  int ack_pct, drain_ack_pct, arb_ack_pct, idle_pct, new_pct;

  exp_t sbq [$];
  int   obs [$];
  int   ackc [2][NP];
  int   preseen [2];
  logic [NP-1:0] prevg [2];

  task automatic chk(input string nm, input int got, input int want);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic int pick(input int d, input logic [NP-1:0] req);
    for (int i = 0; i < NP; i++) begin
      int j;
      j = (d == 0) ? (last[d] + 1 + i) % NP : i;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit busy_any();
    for (int d = 0; d < 2; d++) begin
      if (own[d] >= 0) return 1'b1;
      for (int k = 0; k < NP; k++)
        if (rem[d][k] > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; last[d] = NP - 1; acks[d] = 0; drn[d] = 1'b0;
      refill[d] = 1'b0;
      for (int k = 0; k < NP; k++) begin
        rem[d][k] = 0; was_zero[d][k] = 1'b0;
      end
    end
  endtask

  task automatic policy(input int a, input int da, input int aa, input int id, input int nw);
    ack_pct = a; drain_ack_pct = da; arb_ack_pct = aa; idle_pct = id; new_pct = nw;
  endtask

  task automatic step();
    exp_t e;
    logic [NP-1:0] req;
    bit a, oth;
    int o;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NP; k++) begin
        if (rem[d][k] == 0 && refill[d] && was_zero[d][k]) rem[d][k] = 2;
        else if (rem[d][k] == 0 && pct(new_pct)) rem[d][k] = int'($urandom_range(8, 1));
        was_zero[d][k] = (rem[d][k] == 0);
      end
      req = '0;
      for (int k = 0; k < NP; k++) req[k] = (rem[d][k] > 0);
      pacc[d] = req;
      pwe[d]  = NP'($urandom());
      padr[d] = {$urandom(), $urandom(), $urandom()};
      pdat[d] = 48'({$urandom(), $urandom()});
      psel[d] = 6'($urandom());
      o = own[d];
      if (o < 0) a = pct(arb_ack_pct);
      else if (!drn[d]) a = req[o] && pct(ack_pct);
      else a = (rem[d][o] > 0) && pct(drain_ack_pct);
      ack[d]  = a;
      idle[d] = pct(idle_pct);
      e = '0;
      e.d = 1'(d);
      if (o >= 0) begin
        e.grant = NP'(1) << o;
        e.enc   = 2'(o);
        e.adr   = 32'(padr[d] >> (32 * o));
        e.dat   = 16'(pdat[d] >> (16 * o));
        e.sel   = 2'(psel[d] >> (2 * o));
        e.we    = pwe[d][o];
        e.acc   = !drn[d] && req[o];
      end
      e.pre = drn[d];
      e.pk  = a ? e.grant : '0;
      sbq.push_back(e);
      for (int k = 0; k < NP; k++)
        if (e.pk[k]) rem[d][k]--;
      if (o < 0) begin
        if (req != 0) begin
          own[d] = pick(d, req);
          acks[d] = 0;
        end
      end else if (!drn[d]) begin
        oth = 1'b0;
        for (int j = 0; j < NP; j++)
          if (req[j] && j != o && (d == 0 || j < o)) oth = 1'b1;
        if (!req[o] && idle[d]) begin
          last[d] = o; own[d] = -1;
        end else if (acks[d] == Q && oth) begin
          drn[d] = 1'b1;
        end
        if (a && acks[d] < Q) acks[d]++;
      end else if (idle[d]) begin
        last[d] = o; own[d] = -1; drn[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, input int lim);
    for (int n = 0; n < lim && busy_any(); n++) step();
    chk({nm, "_timeout"}, int'(busy_any()), 0);
  endtask

  // monitor: pop expectations and record observed grants, acks, preempts
  initial begin
    exp_t e;
    bit ok;
    int d;
    for (int i = 0; i < 2; i++) prevg[i] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 2; i++) prevg[i] = '0;
      end else begin
        while (sbq.size() > 0) begin
          e = sbq.pop_front();
          d = int'(e.d);
          ok = (grant[d] === e.grant) && (acc_o[d] === e.acc) &&
               (pre[d] === e.pre) && (pack[d] === e.pk);
          if (e.grant != 0)
            ok = ok && (genc[d] === e.enc) && (adr_o[d] === e.adr) &&
                 (dat_o[d] === e.dat) && (sel_o[d] === e.sel) && (we_o[d] === e.we);
          nchk++;
          if (!ok) begin
            nerr++;
            $display("FAIL sb dut%0d t=%0t got g=%b enc=%0d acc=%b pre=%b ack=%b adr=%h want g=%b enc=%0d acc=%b pre=%b ack=%b adr=%h",
                     d, $time, grant[d], genc[d], acc_o[d], pre[d], pack[d], adr_o[d],
                     e.grant, e.enc, e.acc, e.pre, e.pk, e.adr);
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (grant[i] != 0 && grant[i] != prevg[i])
            for (int k = 0; k < NP; k++)
              if (grant[i][k]) obs.push_back(i * 10 + k);
          prevg[i] = grant[i];
          for (int k = 0; k < NP; k++)
            if (pack[i][k]) ackc[i][k]++;
          if (pre[i]) preseen[i]++;
        end
      end
    end
  end

  task automatic clear_obs();
    obs.delete();
    for (int i = 0; i < 2; i++) begin
      preseen[i] = 0;
      for (int k = 0; k < NP; k++) ackc[i][k] = 0;
    end
  endtask

  function automatic int obs_at(input int i);
    return (obs.size() > i) ? obs[i] : -1;
  endfunction

  initial begin
    int rr_exp [5];
    bit hooked;
    rr_exp = '{0, 1, 2, 0, 1};
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      idle[d] = 1'b0; ack[d] = 1'b1; pacc[d] = '0; pwe[d] = '0;
      padr[d] = '0; pdat[d] = '0; psel[d] = '0;
    end
    model_reset();
    clear_obs();
    @(posedge clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_grant%0d", d), int'(grant[d]), 0);
      chk($sformatf("rst_enc%0d", d), int'(genc[d]), 0);
      chk($sformatf("rst_acc%0d", d), int'(acc_o[d]), 0);
      chk($sformatf("rst_pre%0d", d), int'(pre[d]), 0);
      chk($sformatf("rst_ack%0d", d), int'(pack[d]), 0);
    end
    rst = 1'b0;

    // round-robin fairness: every port re-requests after finishing 2 words
    policy(100, 0, 0, 100, 0);
    clear_obs();
    refill[0] = 1'b1;
    for (int k = 0; k < NP; k++) rem[0][k] = 2;
    for (int n = 0; n < 60 && obs.size() < 5; n++) step();
    refill[0] = 1'b0;
    for (int i = 0; i < 5; i++) chk($sformatf("rr_seq%0d", i), obs_at(i), rr_exp[i]);
    wait_done("rr", 100);

    // fixed priority: 0 beats 2, port 1 arriving mid-burst does not preempt 0
    clear_obs();
    rem[1][0] = 6; rem[1][2] = 3;
    hooked = 1'b0;
    for (int n = 0; n < 100 && busy_any(); n++) begin
      if (!hooked && own[1] == 0 && acks[1] >= 1) begin
        rem[1][1] = 2; hooked = 1'b1;
      end
      step();
    end
    chk("prio_timeout", int'(busy_any()), 0);
    chk("prio_seq0", obs_at(0), 10);
    chk("prio_seq1", obs_at(1), 11);
    chk("prio_seq2", obs_at(2), 12);
    chk("prio_nopre", preseen[1], 0);

    // preemption: port 1 arrives at port 0's second ack of a 10-word burst
    policy(100, 0, 30, 60, 0);
    clear_obs();
    rem[0][0] = 10;
    hooked = 1'b0;
    for (int n = 0; n < 300 && busy_any(); n++) begin
      if (!hooked && rem[0][0] == 8) begin
        rem[0][1] = 3; hooked = 1'b1;
      end
      step();
    end
    chk("pre_timeout", int'(busy_any()), 0);
    chk("pre_seq0", obs_at(0), 0);
    chk("pre_seq1", obs_at(1), 1);
    chk("pre_seq2", obs_at(2), 0);
    chk("pre_seen", int'(preseen[0] > 0), 1);
    chk("pre_acks0", ackc[0][0], 10);
    chk("pre_acks1", ackc[0][1], 3);

    // ack routing: only the owner sees acks, acks in ARB are dropped
    policy(100, 0, 100, 100, 0);
    clear_obs();
    rem[0][2] = 3;
    wait_done("route", 50);
    chk("route_p2", ackc[0][2], 3);
    chk("route_p0", ackc[0][0], 0);
    chk("route_p1", ackc[0][1], 0);

    // release and preempt in the same cycle: release must win
    policy(100, 0, 0, 100, 0);
    clear_obs();
    rem[0][0] = 4;
    hooked = 1'b0;
    for (int n = 0; n < 60 && busy_any(); n++) begin
      if (!hooked && own[0] == 0) begin
        rem[0][1] = 2; hooked = 1'b1;
      end
      step();
    end
    chk("coll_timeout", int'(busy_any()), 0);
    chk("coll_nopre", preseen[0], 0);
    chk("coll_seq0", obs_at(0), 0);
    chk("coll_seq1", obs_at(1), 1);

    // asynchronous reset in the middle of a burst
    policy(100, 0, 0, 100, 0);
    clear_obs();
    rem[0][0] = 6;
    for (int n = 0; n < 20 && !(own[0] == 0 && acks[0] >= 2); n++) step();
    chk("arst_reach", int'(own[0] == 0 && acks[0] >= 2), 1);
    #2;
    ack[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_grant", int'(grant[0]), 0);
    chk("arst_acc", int'(acc_o[0]), 0);
    chk("arst_ack", int'(pack[0]), 0);
    chk("arst_pre", int'(pre[0]), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    clear_obs();
    rem[0][1] = 3; rem[0][2] = 3;
    wait_done("arst", 60);
    chk("arst_first", obs_at(0), 1);
    chk("arst_second", obs_at(1), 2);

    // random traffic on both instances
    policy(70, 30, 20, 60, 15);
    for (int n = 0; n < 3000; n++) step();
    policy(70, 30, 20, 70, 0);
    wait_done("rand", 800);

    @(negedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
